frogger_lane_engine: RTL

//  Generates moving lane contents (cars on road rows 7-11, logs on water rows 1-5) for the frogger playfield.

---
 rtl/frogger_lane_engine_pkg.sv | 56 +++++
 rtl/frogger_lane_engine_lane.sv | 58 +++++
 rtl/frogger_lane_engine.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/frogger_lane_engine_pkg.sv
// Shared constants, lane tables and helpers for the frogger lane engine.
package frogger_lane_engine_pkg;

    localparam int unsigned c_GAME_WIDTH  = 14;
    localparam int unsigned c_NUM_LANES   = 10;
    localparam logic [5:0]  c_WATER_ROW0  = 6'd1;
    localparam logic [5:0]  c_ROAD_ROW0   = 6'd7;
    localparam logic [5:0]  c_LANES_PER_SIDE = 6'd5;
    localparam logic [5:0]  c_HIT_FREEZE  = 6'd60;
    localparam logic [5:0]  c_LAST_COL    = 6'(c_GAME_WIDTH - 1);

    localparam logic [c_GAME_WIDTH-1:0] LANE_SEED [c_NUM_LANES] = '{
        14'b00111100011110, 14'b01110011100111, 14'b11111000111110,
        14'b00111111001111, 14'b11100111001110, 14'b00100000100100,
        14'b01000100000010, 14'b00011000001100, 14'b10000001000001,
        14'b00100100000100
    };

    localparam logic [5:0] LANE_PERIOD [c_NUM_LANES] = '{
        6'd20, 6'd12, 6'd30, 6'd8, 6'd2, 6'd15, 6'd10, 6'd6, 6'd25, 6'd4
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FREEZE
    } state_t;

    typedef struct packed {
        logic       valid;
        logic       road;
        logic [3:0] lane;
    } lane_sel_t;

    // Water rows 1-5 map to lanes 0-4, road rows 7-11 to lanes 5-9.
    function automatic lane_sel_t row_to_lane(input logic [5:0] row);
        lane_sel_t sel;
        sel = '0;
        if (row >= c_WATER_ROW0 && row < c_WATER_ROW0 + c_LANES_PER_SIDE) begin
            sel.valid = 1'b1;
            sel.lane  = 4'(row - c_WATER_ROW0);
        end else if (row >= c_ROAD_ROW0 && row < c_ROAD_ROW0 + c_LANES_PER_SIDE) begin
            sel.valid = 1'b1;
            sel.road  = 1'b1;
            sel.lane  = 4'(row - c_ROAD_ROW0 + c_LANES_PER_SIDE);
        end
        return sel;
    endfunction

    function automatic logic [5:0] eff_period_m1(input logic [5:0] period, input logic [1:0] level);
        logic [5:0] shifted;
        shifted = period >> level;
        return (shifted == '0) ? '0 : shifted - 6'd1;
    endfunction

endpackage

// File: rtl/frogger_lane_engine_lane.sv
// One scrolling lane: pattern register plus frame counter that rotates the
// pattern one tile every (period_m1 + 1) enabled ticks.
module frogger_lane
    import frogger_lane_engine_pkg::*;
#(
    parameter logic [c_GAME_WIDTH-1:0] SEED = '0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_tick,
    input  logic                    i_enable,
    input  logic                    i_reload,
    input  logic                    i_dir_right,
    input  logic [5:0]              i_period_m1,
    output logic [c_GAME_WIDTH-1:0] o_pattern,
    output logic                    o_rotated
);

    logic [c_GAME_WIDTH-1:0] pattern_q, pattern_d;
    logic [5:0]              count_q, count_d;
    logic                    rotated_q, rotated_d;

    always_comb begin
        pattern_d = pattern_q;
        count_d   = count_q;
        rotated_d = 1'b0;
        if (i_reload) begin
            pattern_d = SEED;
            count_d   = '0;
        end else if (i_tick && i_enable) begin
            if (count_q == i_period_m1) begin
                count_d   = '0;
                rotated_d = 1'b1;
                pattern_d = i_dir_right
                    ? {pattern_q[c_GAME_WIDTH-2:0], pattern_q[c_GAME_WIDTH-1]}
                    : {pattern_q[0], pattern_q[c_GAME_WIDTH-1:1]};
            end else begin
                count_d = count_q + 6'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pattern_q <= SEED;
            count_q   <= '0;
            rotated_q <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            count_q   <= count_d;
            rotated_q <= rotated_d;
        end
    end

    assign o_pattern = pattern_q;
    assign o_rotated = rotated_q;

endmodule

// File: rtl/frogger_lane_engine.sv
// Lane scroller for the frogger playfield: frame tick detection, run/freeze
// FSM, renderer occupancy lookup and once-per-frame frog collision check.
module frogger_lane_engine
    import frogger_lane_engine_pkg::*;
(
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_VSync,
    input  logic       i_Game_Active,
    input  logic [1:0] i_Level,
    input  logic [4:0] i_Col_Count_Div,
    input  logic [4:0] i_Row_Count_Div,
    input  logic [5:0] i_Frogger_X,
    input  logic [5:0] i_Frogger_Y,
    output logic       o_Obstacle,
    output logic       o_Frog_Hit,
    output logic       o_Carry_Left,
    output logic       o_Carry_Right
);

    logic                    vsync_q, vsync_prev_q, tick;
    state_t                  state_q, state_d;
    logic [5:0]              frz_q, frz_d;
    logic                    check_q, check_d;
    logic                    obstacle_q, obstacle_d;
    logic                    hit_q, hit_d;
    logic                    carry_l_q, carry_l_d;
    logic                    carry_r_q, carry_r_d;
    logic [c_GAME_WIDTH-1:0] pattern [c_NUM_LANES];
    logic [c_NUM_LANES-1:0]  rotated;
    logic                    lanes_reload, lanes_enable;
    lane_sel_t               look_sel, frog_sel;
    logic                    frog_bit;

    assign tick         = vsync_prev_q & ~vsync_q;
    assign lanes_reload = (state_q == ST_IDLE);
    assign lanes_enable = (state_q == ST_RUN);

    for (genvar g = 0; g < c_NUM_LANES; g++) begin : g_lane
        frogger_lane #(.SEED(LANE_SEED[g])) u_lane (
            .i_clk       (i_Clk),
            .i_rst       (i_Rst),
            .i_tick      (tick),
            .i_enable    (lanes_enable),
            .i_reload    (lanes_reload),
            .i_dir_right ((g % 2) == 1),
            .i_period_m1 (eff_period_m1(LANE_PERIOD[g], i_Level)),
            .o_pattern   (pattern[g]),
            .o_rotated   (rotated[g])
        );
    end

    // Lookup samples the registered patterns, so a same-cycle tick is not yet visible.
    always_comb begin
        obstacle_d = 1'b0;
        look_sel   = row_to_lane({1'b0, i_Row_Count_Div});
        if (look_sel.valid && {1'b0, i_Col_Count_Div} <= c_LAST_COL) begin
            obstacle_d = pattern[look_sel.lane][i_Col_Count_Div[3:0]];
        end
    end

    always_comb begin
        hit_d     = 1'b0;
        carry_l_d = 1'b0;
        carry_r_d = 1'b0;
        frog_bit  = 1'b0;
        frog_sel  = row_to_lane(i_Frogger_Y);
        if (check_q && state_q == ST_RUN && i_Game_Active && frog_sel.valid
            && i_Frogger_X <= c_LAST_COL) begin
            frog_bit = pattern[frog_sel.lane][i_Frogger_X[3:0]];
            if (frog_sel.road) begin
                hit_d = frog_bit;
            end else if (!frog_bit) begin
                hit_d = 1'b1;
            end else if (rotated[frog_sel.lane]) begin
                // Odd lanes drift right, even lanes left; riding off the edge is fatal.
                if (frog_sel.lane[0]) begin
                    if (i_Frogger_X == c_LAST_COL) hit_d = 1'b1;
                    else                           carry_r_d = 1'b1;
                end else begin
                    if (i_Frogger_X == '0) hit_d = 1'b1;
                    else                   carry_l_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        frz_d   = frz_q;
        check_d = tick && (state_q == ST_RUN);
        case (state_q)
            ST_IDLE:   if (i_Game_Active) state_d = ST_RUN;
            ST_RUN: begin
                if (hit_d) begin
                    state_d = ST_FREEZE;
                    frz_d   = '0;
                end
            end
            ST_FREEZE: begin
                if (tick) begin
                    if (frz_q == c_HIT_FREEZE - 6'd1) begin
                        state_d = ST_RUN;
                        frz_d   = '0;
                    end else begin
                        frz_d = frz_q + 6'd1;
                    end
                end
            end
            default:   state_d = ST_IDLE;
        endcase
        if (!i_Game_Active) state_d = ST_IDLE;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            vsync_q      <= 1'b0;
            vsync_prev_q <= 1'b0;
            state_q      <= ST_IDLE;
            frz_q        <= '0;
            check_q      <= 1'b0;
            obstacle_q   <= 1'b0;
            hit_q        <= 1'b0;
            carry_l_q    <= 1'b0;
            carry_r_q    <= 1'b0;
        end else begin
            vsync_q      <= i_VSync;
            vsync_prev_q <= vsync_q;
            state_q      <= state_d;
            frz_q        <= frz_d;
            check_q      <= check_d;
            obstacle_q   <= obstacle_d;
            hit_q        <= hit_d;
            carry_l_q    <= carry_l_d;
            carry_r_q    <= carry_r_d;
        end
    end

    assign o_Obstacle    = obstacle_q;
    assign o_Frog_Hit    = hit_q;
    assign o_Carry_Left  = carry_l_q;
    assign o_Carry_Right = carry_r_q;

endmodule
